// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: width codes, FSM states and defaults shared by the data-memory responder.
package dmem_resp_pkg;

    localparam int DEPTH_LOG2_DEF = 12;

    localparam logic [1:0] DW_BYTE = 2'b00;
    localparam logic [1:0] DW_HALF = 2'b01;
    localparam logic [1:0] DW_WORD = 2'b10;

    typedef enum logic {
        DMEM_IDLE  = 1'b0,
        DMEM_SPLIT = 1'b1
    } dmem_state_t;

    // Width code 11 behaves as a word access.
    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        return (w == DW_BYTE) ? 3'd1 : (w == DW_HALF) ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: shifts a {hi,lo} SRAM word pair by the byte offset and size/sign-extends the load result.
module dmem_load_align
    import dmem_resp_pkg::*;
(
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_width,
    input  logic        i_sign,
    output logic [31:0] o_data
);

    logic [31:0] w_sh;

    assign w_sh   = 32'({i_hi, i_lo} >> {i_off, 3'b000});
    assign o_data = (i_width == DW_BYTE) ? {{24{i_sign & w_sh[7]}}, w_sh[7:0]} :
                    (i_width == DW_HALF) ? {{16{i_sign & w_sh[15]}}, w_sh[15:0]} : w_sh;

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: Mem-stage data-memory responder driving a single-port 32-bit word SRAM.
// DMEM_MISALIGN_SPLIT_EN: word-crossing accesses run as two SRAM beats; otherwise they raise Dcache_AddrErr.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Mem_DcacheEN,
    input  logic                  Mem_DcacheRd,
    input  logic [1:0]            Mem_DcacheWidth,
    input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
    input  logic                  Mem_DcacheSign,
    input  logic [DATA_WIDTH-1:0] Mem_DcacheWData,
    input  logic                  Csr_Memflush,
    output logic                  Dcache_Stall,
    output logic                  Dcache_RdValid,
    output logic [DATA_WIDTH-1:0] Dcache_RdData,
    output logic                  Dcache_AddrErr,
    output logic                  Sram_CE,
    output logic                  Sram_WE,
    output logic [3:0]            Sram_BE,
    output logic [DEPTH_LOG2-1:0] Sram_Addr,
    output logic [DATA_WIDTH-1:0] Sram_WData,
    input  logic [DATA_WIDTH-1:0] Sram_RData
);

    logic [1:0]            w_off;
    logic [2:0]            w_size;
    logic                  w_cross;
    logic                  w_acc;
    logic                  w_in_split;
    logic                  w_split_ld;
    logic                  w_stall;
    logic [7:0]            w_be8;
    logic [63:0]           w_wd64;
    logic [DEPTH_LOG2-1:0] w_word;
    logic [31:0]           w_al_hi;
    logic [31:0]           w_al_lo;
    logic [31:0]           w_al_data;
    logic                  w_unused;
    logic                  r_vld;
    logic                  r_sign;
    logic [1:0]            r_off;
    logic [1:0]            r_width;

    assign w_off    = Mem_DcacheAddr[1:0];
    assign w_size   = width_bytes(Mem_DcacheWidth);
    assign w_cross  = ({1'b0, w_off} + w_size) > 3'd4;
    // A flushed store is dropped entirely; loads are never flushed.
    assign w_acc    = Mem_DcacheEN & ~(Csr_Memflush & ~Mem_DcacheRd);
    assign w_word   = Mem_DcacheAddr[DEPTH_LOG2+1:2];
    assign w_be8    = ((8'd1 << w_size) - 8'd1) << w_off;
    assign w_wd64   = {32'd0, Mem_DcacheWData} << {w_off, 3'b000};
    assign w_unused = &{1'b0, Mem_DcacheAddr[ADDR_WIDTH-1:DEPTH_LOG2+2], w_be8[7:4], w_wd64[63:32]};

    assign Dcache_Stall   = ~rst & w_stall;
    assign Dcache_RdValid = r_vld;
    assign Dcache_RdData  = r_vld ? w_al_data : '0;

    dmem_load_align u_align (
        .i_hi    (w_al_hi),
        .i_lo    (w_al_lo),
        .i_off   (r_off),
        .i_width (r_width),
        .i_sign  (r_sign),
        .o_data  (w_al_data)
    );

`ifdef DMEM_MISALIGN_SPLIT_EN
    dmem_state_t           r_state;
    logic                  r_rd;
    logic                  r_vld_split;
    logic [3:0]            r_hi_be;
    logic [31:0]           r_hi_wdata;
    logic [31:0]           r_lo;
    logic [DEPTH_LOG2-1:0] r_next_word;

    assign w_in_split     = r_state == DMEM_SPLIT;
    assign w_split_ld     = w_in_split & r_rd;
    assign w_stall        = ~w_in_split & w_acc & w_cross;
    assign w_al_hi        = r_vld_split ? Sram_RData : '0;
    assign w_al_lo        = r_vld_split ? r_lo : Sram_RData;
    assign Dcache_AddrErr = 1'b0;
    // The high beat ignores Csr_Memflush so a split store always completes.
    assign Sram_CE        = ~rst & (w_in_split | w_acc);
    assign Sram_WE        = w_in_split ? ~r_rd : ~Mem_DcacheRd;
    assign Sram_BE        = w_in_split ? r_hi_be : w_be8[3:0];
    assign Sram_Addr      = w_in_split ? r_next_word : w_word;
    assign Sram_WData     = w_in_split ? r_hi_wdata : w_wd64[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DMEM_IDLE;
            r_rd        <= 1'b0;
            r_vld_split <= 1'b0;
            r_hi_be     <= '0;
            r_hi_wdata  <= '0;
            r_lo        <= '0;
            r_next_word <= '0;
        end else begin
            r_state     <= w_stall ? DMEM_SPLIT : DMEM_IDLE;
            r_vld_split <= w_in_split;
            if (w_in_split) r_lo <= Sram_RData;
            if (w_stall) begin
                r_rd        <= Mem_DcacheRd;
                r_hi_be     <= w_be8[7:4];
                r_hi_wdata  <= w_wd64[63:32];
                r_next_word <= w_word + DEPTH_LOG2'(1);
            end
        end
    end
`else
    logic r_err;

    assign w_in_split     = 1'b0;
    assign w_split_ld     = 1'b0;
    assign w_stall        = 1'b0;
    assign w_al_hi        = '0;
    assign w_al_lo        = Sram_RData;
    assign Dcache_AddrErr = r_err;
    assign Sram_CE        = ~rst & w_acc & ~w_cross;
    assign Sram_WE        = ~Mem_DcacheRd;
    assign Sram_BE        = w_be8[3:0];
    assign Sram_Addr      = w_word;
    assign Sram_WData     = w_wd64[31:0];

    always_ff @(posedge clk) begin
        r_err <= rst ? 1'b0 : w_acc & w_cross;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= 1'b0;
            r_off   <= '0;
            r_width <= '0;
            r_sign  <= 1'b0;
        end else begin
            r_vld <= w_in_split ? w_split_ld : w_acc & Mem_DcacheRd & ~w_cross;
            if (~w_in_split & Mem_DcacheEN) begin
                r_off   <= w_off;
                r_width <= Mem_DcacheWidth;
                r_sign  <= Mem_DcacheSign;
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed scoreboard bench for dmem_resp with a behavioural byte-enabled SRAM.
// Split-access cases are exercised when DMEM_MISALIGN_SPLIT_EN is defined, address-error cases otherwise.
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Mem_DcacheEN = 1'b0;
    logic        Mem_DcacheRd = 1'b1;
    logic [1:0]  Mem_DcacheWidth = DW_WORD;
    logic [31:0] Mem_DcacheAddr = '0;
    logic        Mem_DcacheSign = 1'b0;
    logic [31:0] Mem_DcacheWData = '0;
    logic        Csr_Memflush = 1'b0;
    logic        Dcache_Stall;
    logic        Dcache_RdValid;
    logic [31:0] Dcache_RdData;
    logic        Dcache_AddrErr;
    logic        Sram_CE;
    logic        Sram_WE;
    logic [3:0]  Sram_BE;
    logic [11:0] Sram_Addr;
    logic [31:0] Sram_WData;
    logic [31:0] Sram_RData = '0;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] mem [0:4095];

    dmem_resp u_dut (
        .clk             (clk),
        .rst             (rst),
        .Mem_DcacheEN    (Mem_DcacheEN),
        .Mem_DcacheRd    (Mem_DcacheRd),
        .Mem_DcacheWidth (Mem_DcacheWidth),
        .Mem_DcacheAddr  (Mem_DcacheAddr),
        .Mem_DcacheSign  (Mem_DcacheSign),
        .Mem_DcacheWData (Mem_DcacheWData),
        .Csr_Memflush    (Csr_Memflush),
        .Dcache_Stall    (Dcache_Stall),
        .Dcache_RdValid  (Dcache_RdValid),
        .Dcache_RdData   (Dcache_RdData),
        .Dcache_AddrErr  (Dcache_AddrErr),
        .Sram_CE         (Sram_CE),
        .Sram_WE         (Sram_WE),
        .Sram_BE         (Sram_BE),
        .Sram_Addr       (Sram_Addr),
        .Sram_WData      (Sram_WData),
        .Sram_RData      (Sram_RData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (Sram_CE) begin
            if (Sram_WE) begin
                for (int i = 0; i < 4; i++)
                    if (Sram_BE[i]) mem[Sram_Addr][8*i +: 8] <= Sram_WData[8*i +: 8];
            end else begin
                Sram_RData <= mem[Sram_Addr];
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    always @(negedge clk) begin
        if (Dcache_RdValid || Dcache_AddrErr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {30'd0, Dcache_RdValid, Dcache_AddrErr}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_kind", {30'd0, Dcache_RdValid, Dcache_AddrErr}, {30'd0, ~mon_e.err, mon_e.err});
                chk("resp_data", Dcache_RdData, mon_e.data);
                chk("resp_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Mem_DcacheEN = 1'b0;
        Mem_DcacheRd = 1'b1;
        Csr_Memflush = 1'b0;
    endtask

    // lat = 0: no response expected; otherwise the response is due lat cycles later.
    task automatic req(input logic rd, input logic [1:0] w, input logic [31:0] a, input logic s,
                       input logic [31:0] wd, input logic fl, input logic er, input logic [31:0] ed, input int lat);
        exp_t e;
        Mem_DcacheEN    = 1'b1;
        Mem_DcacheRd    = rd;
        Mem_DcacheWidth = w;
        Mem_DcacheAddr  = a;
        Mem_DcacheSign  = s;
        Mem_DcacheWData = wd;
        Csr_Memflush    = fl;
        if (lat > 0) begin
            e.err  = er;
            e.data = ed;
            e.due  = 32'(cyc + lat);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        req(0, DW_WORD, 32'h100, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        repeat (2) tick();
        @(negedge clk);
        chk("rst_ce", {31'd0, Sram_CE}, 0);
        chk("rst_rdvalid", {31'd0, Dcache_RdValid}, 0);
        chk("rst_rddata", Dcache_RdData, 0);
        chk("rst_addrerr", {31'd0, Dcache_AddrErr}, 0);
        chk("rst_stall", {31'd0, Dcache_Stall}, 0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        req(0, DW_WORD, 32'h100, 0, 32'h1122_3344, 0, 0, 0, 0);
        @(negedge clk);
        chk("sw_ce", {31'd0, Sram_CE}, 1);
        chk("sw_we", {31'd0, Sram_WE}, 1);
        chk("sw_be", {28'd0, Sram_BE}, 4'hF);
        chk("sw_addr", {20'd0, Sram_Addr}, 12'h040);
        chk("sw_stall", {31'd0, Dcache_Stall}, 0);
        tick();
        req(1, DW_BYTE, 32'h103, 1, 0, 0, 0, 32'h0000_0011, 1); tick();
        req(1, DW_HALF, 32'h102, 1, 0, 0, 0, 32'h0000_1122, 1); tick();
        req(0, DW_BYTE, 32'h204, 0, 32'h0000_0080, 0, 0, 0, 0);
        @(negedge clk);
        chk("sb_be", {28'd0, Sram_BE}, 4'b0001);
        chk("sb_wdata", Sram_WData, 32'h0000_0080);
        tick();
        req(1, DW_BYTE, 32'h204, 1, 0, 0, 0, 32'hFFFF_FF80, 1); tick();
        req(1, DW_BYTE, 32'h204, 0, 0, 0, 0, 32'h0000_0080, 1); tick();
        req(0, DW_HALF, 32'h206, 0, 32'h0000_BEEF, 0, 0, 0, 0);
        @(negedge clk);
        chk("sh_be", {28'd0, Sram_BE}, 4'b1100);
        chk("sh_wdata", Sram_WData, 32'hBEEF_0000);
        tick();
        req(1, DW_HALF, 32'h206, 1, 0, 0, 0, 32'hFFFF_BEEF, 1); tick();
        req(1, 2'b11,   32'h204, 0, 0, 0, 0, 32'hBEEF_0080, 1); tick();
        req(1, DW_HALF, 32'h100, 1, 0, 0, 0, 32'h0000_3344, 1); tick();
        req(0, DW_WORD, 32'h100, 0, 32'hDEAD_BEEF, 1, 0, 0, 0);
        @(negedge clk);
        chk("flush_ce", {31'd0, Sram_CE}, 0);
        tick();
        req(1, DW_WORD, 32'h100, 0, 0, 0, 0, 32'h1122_3344, 1); tick();
        idle();
        tick();

`ifdef DMEM_MISALIGN_SPLIT_EN
        req(0, DW_WORD, 32'h302, 0, 32'hAABB_CCDD, 0, 0, 0, 0);
        @(negedge clk);
        chk("split_lo_stall", {31'd0, Dcache_Stall}, 1);
        chk("split_lo_be", {28'd0, Sram_BE}, 4'b1100);
        chk("split_lo_addr", {20'd0, Sram_Addr}, 12'h0C0);
        chk("split_lo_wdata", Sram_WData, 32'hCCDD_0000);
        tick();
        @(negedge clk);
        chk("split_hi_stall", {31'd0, Dcache_Stall}, 0);
        chk("split_hi_ce", {31'd0, Sram_CE}, 1);
        chk("split_hi_be", {28'd0, Sram_BE}, 4'b0011);
        chk("split_hi_addr", {20'd0, Sram_Addr}, 12'h0C1);
        chk("split_hi_wdata", Sram_WData, 32'h0000_AABB);
        tick();
        req(1, DW_WORD, 32'h302, 0, 0, 0, 0, 32'hAABB_CCDD, 2); tick(); tick();
        req(0, DW_BYTE, 32'h3FFF, 0, 32'h0000_005A, 0, 0, 0, 0); tick();
        req(0, DW_BYTE, 32'h0000, 0, 32'h0000_00A5, 0, 0, 0, 0); tick();
        req(1, DW_HALF, 32'h3FFF, 1, 0, 0, 0, 32'hFFFF_A55A, 2);
        @(negedge clk);
        chk("wrap_lo_addr", {20'd0, Sram_Addr}, 12'hFFF);
        chk("wrap_lo_be", {28'd0, Sram_BE}, 4'b1000);
        tick();
        @(negedge clk);
        chk("wrap_hi_addr", {20'd0, Sram_Addr}, 12'h000);
        chk("wrap_hi_be", {28'd0, Sram_BE}, 4'b0001);
        tick();
        req(0, DW_WORD, 32'h401, 0, 32'h0102_0304, 0, 0, 0, 0); tick();
        Csr_Memflush = 1'b1;
        tick();
        req(1, DW_WORD, 32'h401, 0, 0, 0, 0, 32'h0102_0304, 2); tick(); tick();
        req(1, DW_WORD, 32'h400, 0, 0, 0, 0, 32'h0203_0400, 1); tick();
        req(1, DW_WORD, 32'h302, 0, 0, 0, 0, 0, 0); tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_split_ce", {31'd0, Sram_CE}, 0);
        tick();
        rst = 1'b0;
        idle();
        tick();
        req(1, DW_WORD, 32'h300, 0, 0, 0, 0, 32'hCCDD_0000, 1); tick();
`else
        req(1, DW_WORD, 32'h101, 0, 0, 0, 1, 0, 1);
        @(negedge clk);
        chk("err_ce", {31'd0, Sram_CE}, 0);
        chk("err_stall", {31'd0, Dcache_Stall}, 0);
        tick();
        req(1, DW_HALF, 32'h103, 1, 0, 0, 1, 0, 1); tick();
        idle();
        tick();
        req(0, DW_WORD, 32'h302, 0, 32'hAABB_CCDD, 0, 1, 0, 1);
        @(negedge clk);
        chk("err_st_ce", {31'd0, Sram_CE}, 0);
        tick();
        req(0, DW_WORD, 32'h302, 0, 32'hAABB_CCDD, 1, 0, 0, 0);
        @(negedge clk);
        chk("flush_err_ce", {31'd0, Sram_CE}, 0);
        tick();
        req(1, DW_WORD, 32'h300, 0, 0, 0, 0, 32'h0000_0000, 1); tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        req(1, DW_WORD, 32'h100, 0, 0, 0, 0, 32'h1122_3344, 1); tick();
`endif
        idle();
        repeat (4) tick();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Responder side of the Mem-stage data-memory request interface.
- Accepts the per-cycle request (enable, read/write, width, address, sign, store data) and drives a synchronous single-port 32-bit word SRAM.
- Returns aligned, sign- or zero-extended load data to writeback.
- Splits word-crossing accesses into two SRAM beats and stalls the pipeline for one cycle while it does so.

Parameters:
- DEPTH_LOG2, 12, SRAM word-address width (4096 words).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width; fixed at 32.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- Mem_DcacheEN  in  1  request valid this cycle.
- Mem_DcacheRd  in  1  1=load, 0=store.
- Mem_DcacheWidth  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- Mem_DcacheAddr  in  ADDR_WIDTH  byte address.
- Mem_DcacheSign  in  1  load sign-extend.
- Mem_DcacheWData  in  DATA_WIDTH  store data, LSB-justified.
- Csr_Memflush  in  1  suppress a store issued this cycle.
- Dcache_Stall  out  1  hold the Mem-stage request; combinational.
- Dcache_RdValid  out  1  load result valid.
- Dcache_RdData  out  DATA_WIDTH  extended load result.
- Dcache_AddrErr  out  1  misaligned-access error pulse (feature-dependent).
- Sram_CE  out  1  SRAM access enable.
- Sram_WE  out  1  SRAM write.
- Sram_BE  out  4  byte enables.
- Sram_Addr  out  DEPTH_LOG2  word address.
- Sram_WData  out  DATA_WIDTH  lane-aligned write data.
- Sram_RData  in  DATA_WIDTH  read data, valid the cycle after CE with WE=0.

Behaviour:
- Reset: synchronous; state=IDLE; all registered state cleared.
  - Dcache_RdValid=0, Dcache_RdData=0, Dcache_AddrErr=0, Dcache_Stall=0, Sram_CE=0.
- Definitions: off=Addr[1:0]; size=1/2/4 bytes; crossing = off+size>4 (half off 3; word off 1/2/3).
- SRAM drive: combinational from the request in IDLE and from latched state in SPLIT.
- Byte enables: BE = ((1<<size)-1)<<off, truncated to 4 bits for the low beat.
  - High beat BE = the remaining low-order bytes.
  - WData is shifted left by 8*off; the high beat carries the remaining upper bytes.
- Store suppression: Csr_Memflush=1 with Rd=0 in IDLE forces CE=0; no write, no error.
- Non-crossing access:
  - Single beat; Dcache_Stall=0.
  - Load: Dcache_RdValid=1 exactly one cycle later. RdData = Sram_RData>>(8*off), masked to size, sign-extended if Sign, else zero-extended.
  - Store: commits at the request cycle's edge.
- Back-to-back requests: accepted every cycle.
- FSM states: IDLE, SPLIT.
  - IDLE -> SPLIT on EN & crossing (feature on, not flushed store).
    - Issue the low beat at word Addr[DEPTH_LOG2+1:2].
    - Stall=1 in that cycle.
    - Latch width, sign, off, Rd, WData, and next word address = (word+1) mod 2^DEPTH_LOG2, wrapping at the top.
  - SPLIT -> IDLE unconditionally.
    - Issue the high beat; Stall=0, so the pipeline advances at the end of SPLIT.
    - Csr_Memflush is ignored in SPLIT: split stores complete atomically.
    - Low-beat read data, arriving this cycle, is captured.
- Split load: Dcache_RdValid=1 two cycles after first issue. Data = {high RData, low RData} shifted by 8*off, then extended.
- A new request may be accepted in the cycle after SPLIT.
- Reset during SPLIT: the high beat is dropped and the state returns to IDLE; no RdValid.
- Dcache_RdValid is never asserted for stores.

Optional Feature:
- Macro: DMEM_MISALIGN_SPLIT_EN.
- Defined: crossing accesses use the SPLIT sequence above; Dcache_AddrErr is tied 0.
- Undefined: on a crossing request, CE=0 and Stall=0.
  - Dcache_AddrErr=1 for exactly one cycle, the cycle after the request.
  - RdValid=0; the SPLIT state is not built.

Decomposition:
- Shared package/Define file:
  - Width codes DW_BYTE/DW_HALF/DW_WORD.
  - FSM state encodings DMEM_IDLE/DMEM_SPLIT.
  - DEPTH_LOG2 default.
- One sub-module, dmem_load_align: combinational. Takes a 64-bit {hi,lo} word pair plus off, width and sign, and produces the extended 32-bit result. It serves both single-beat (hi=0) and split loads.

Test Plan:
- Store word 0x11223344 @0x100, then LB sign @0x103 -> RdValid next cycle, RdData=0x00000011; then LH sign @0x102 -> 0x00001122.
- Store byte 0x80 @0x204 (BE=0001), then LB sign @0x204 -> 0xFFFFFF80; LBU -> 0x00000080.
- Feature on, word store 0xAABBCCDD @0x302:
  - Stall=1 for one cycle; low beat BE=1100 @word 0xC0, high beat BE=0011 @word 0xC1.
  - LW @0x302 -> RdValid two cycles after issue, RdData=0xAABBCCDD.
- Feature on, LH @ top word byte 3, address (2^DEPTH_LOG2-1)*4+3 -> high beat at word address 0 (wrap).
- Store with Csr_Memflush=1 -> CE=0, memory unchanged on readback. Flush asserted in SPLIT of a split store -> both beats written.
- Feature off, LW @0x101 -> AddrErr=1 next cycle for one cycle, CE=0, RdValid=0.
- Reset asserted mid-SPLIT -> no RdValid; next request is serviced normally.
